rom_alu_sequencer: RTL and testbench

//  Fetch/execute controller tying the 12-bit program counter (contador), the 12x8 program ROM
//  and the 4-bit ALU into a nibble-wide programmable engine. Drives the counter's enable/load,

---
 rtl/seq_pkg.sv | 45 ++++
 rtl/seq_decode.sv | 60 ++++++
 rtl/rom_alu_sequencer.sv | 107 ++++++++++
 tb/tb_rom_alu_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the ROM/ALU fetch-execute sequencer.
package seq_pkg;

  localparam int unsigned PC_W    = 12;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned PAGE_W  = PC_W - NIB_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  localparam logic [OP_W-1:0]  OP_LDI      = 4'b1000;
  localparam logic [OP_W-1:0]  OP_OUT      = 4'b1001;
  localparam logic [OP_W-1:0]  OP_JMP      = 4'b1010;
  localparam logic [OP_W-1:0]  OP_JZ       = 4'b1011;
  localparam logic [OP_W-1:0]  OP_HLT      = 4'b1111;
  localparam logic [SEL_W-1:0] ALU_SEL_NOP = 3'b011;

  // Decoded control bundle for one EXEC cycle.
  typedef struct packed {
    logic              pc_enable;
    logic              pc_load;
    logic [PC_W-1:0]   pc_load_val;
    logic [SEL_W-1:0]  alu_sel;
    logic              acc_we;
    logic              acc_imm;
    logic              out_we;
    logic              halt;
  } dec_t;

  function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] ir);
    return ir[INSTR_W-1 -: OP_W];
  endfunction

  function automatic logic [NIB_W-1:0] imm_of(input logic [INSTR_W-1:0] ir);
    return ir[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: instruction register + accumulator -> control bundle.
module seq_decode
  import seq_pkg::*;
(
  input  logic               exec_i,
  input  logic [INSTR_W-1:0] ir_i,
  input  logic [NIB_W-1:0]   acc_i,
  input  logic [PAGE_W-1:0]  pc_page_i,
  output dec_t               dec_o
);

  logic [OP_W-1:0]  op;
  logic [PC_W-1:0]  jump_target;

  assign op          = op_of(ir_i);
  assign jump_target = {pc_page_i, imm_of(ir_i)};

  // Decode the opcode; everything stays inactive outside EXEC.
  always_comb begin
    dec_o = '0;
    if (exec_i) begin
      if (!ir_i[INSTR_W-1]) begin
        dec_o.alu_sel   = ir_i[INSTR_W-2 -: SEL_W];
        dec_o.acc_we    = (ir_i[INSTR_W-2 -: SEL_W] != ALU_SEL_NOP);
        dec_o.pc_enable = 1'b1;
      end else begin
        unique case (op)
          OP_LDI: begin
            dec_o.acc_we    = 1'b1;
            dec_o.acc_imm   = 1'b1;
            dec_o.pc_enable = 1'b1;
          end
          OP_OUT: begin
            dec_o.out_we    = 1'b1;
            dec_o.pc_enable = 1'b1;
          end
          OP_JMP: begin
            dec_o.pc_load     = 1'b1;
            dec_o.pc_load_val = jump_target;
          end
          OP_JZ: begin
            if (acc_i == '0) begin
              dec_o.pc_load     = 1'b1;
              dec_o.pc_load_val = jump_target;
            end else begin
              dec_o.pc_enable = 1'b1;
            end
          end
          OP_HLT: begin
            dec_o.halt = 1'b1;
          end
          default: begin
            dec_o.pc_enable = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/rom_alu_sequencer.sv
// Fetch/execute controller driving an external counter, program ROM and 4-bit ALU.
module rom_alu_sequencer
  import seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic [NIB_W-1:0]   alu_out,
  output logic               pc_enable,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic [PC_W-1:0]    rom_addr,
  output logic [NIB_W-1:0]   alu_a,
  output logic [NIB_W-1:0]   alu_b,
  output logic [SEL_W-1:0]   alu_sel,
  output logic [NIB_W-1:0]   acc,
  output logic [NIB_W-1:0]   out_data,
  output logic               out_valid,
  output logic               busy,
  output logic               halted
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [NIB_W-1:0]   acc_q, acc_d;
  logic [NIB_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  dec_t               dec;

  seq_decode u_decode (
    .exec_i    (state_q == ST_EXEC),
    .ir_i      (ir_q),
    .acc_i     (acc_q),
    .pc_page_i (pc[PC_W-1:NIB_W]),
    .dec_o     (dec)
  );

  // Datapath taps: ROM follows the counter, ALU sees accumulator and immediate.
  assign rom_addr  = pc;
  assign alu_a     = acc_q;
  assign alu_b     = imm_of(ir_q);
  assign alu_sel   = dec.alu_sel;
  assign acc       = acc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted    = (state_q == ST_HALTED);

  // Next-state, register updates and counter strobes.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    pc_enable   = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;

    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = rom_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_enable   = dec.pc_enable;
        pc_load     = dec.pc_load;
        pc_load_val = dec.pc_load_val;
        if (dec.acc_we) begin
          acc_d = dec.acc_imm ? imm_of(ir_q) : alu_out;
        end
        if (dec.out_we) begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
        end
        state_d = dec.halt ? ST_HALTED : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_rom_alu_sequencer.sv
// Directed bench: sequencer plus behavioural counter, ROM and ALU.
module tb_rom_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] pc;
  logic [7:0]  rom_data;
  logic [3:0]  alu_out;
  logic        pc_enable, pc_load;
  logic [11:0] pc_load_val, rom_addr;
  logic [3:0]  alu_a, alu_b, acc, out_data;
  logic [2:0]  alu_sel;
  logic        out_valid, busy, halted;

  logic [7:0]  rom_mem [0:4095];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rom_alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc          (pc),
    .rom_data    (rom_data),
    .alu_out     (alu_out),
    .pc_enable   (pc_enable),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .rom_addr    (rom_addr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .acc         (acc),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .busy        (busy),
    .halted      (halted)
  );

  // Program counter: load has priority over count, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         pc <= 12'h000;
    else if (pc_load)   pc <= pc_load_val;
    else if (pc_enable) pc <= 12'(pc + 12'd1);
  end

  assign rom_data = rom_mem[rom_addr];

  // ALU: 000 AND, 001 OR, 010 ADD, 011 pass A, 100 SUB, 101 XOR, 110 NOT A, 111 pass B.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_out = alu_a & alu_b;
      3'b001:  alu_out = alu_a | alu_b;
      3'b010:  alu_out = 4'(alu_a + alu_b);
      3'b011:  alu_out = alu_a;
      3'b100:  alu_out = 4'(alu_a - alu_b);
      3'b101:  alu_out = alu_a ^ alu_b;
      3'b110:  alu_out = ~alu_a;
      default: alu_out = alu_b;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'hC0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    fill_rom();
    step();
    checks++;
    if ({busy, halted, pc_enable, pc_load, out_valid} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000", {busy, halted, pc_enable, pc_load, out_valid});
    end
    checks++;
    if ({acc, out_data, alu_sel} !== 11'd0) begin
      errors++;
      $display("FAIL reset_regs: acc=%h out=%h sel=%b expected all zero", acc, out_data, alu_sel);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_mid_exec_reset();
    fill_rom();
    rom_mem[0] = 8'h85;
    rom_mem[1] = 8'h23;
    start = 1'b1;
    #1;
    checks++;
    if (pc_load !== 1'b1 || pc_load_val !== 12'h000 || pc_enable !== 1'b0) begin
      errors++;
      $display("FAIL idle_start: load=%b val=%h en=%b expected 1 000 0", pc_load, pc_load_val, pc_enable);
    end
    step();
    start = 1'b0;
    step();
    step();
    step();
    checks++;
    if (acc !== 4'h5 || pc_enable !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_exec: acc=%h en=%b busy=%b expected 5 1 1", acc, pc_enable, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, halted, pc_enable, pc_load, out_valid} !== 5'b00000 || acc !== 4'h0) begin
      errors++;
      $display("FAIL mid_exec_reset: flags=%b acc=%h expected 00000 0",
               {busy, halted, pc_enable, pc_load, out_valid}, acc);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_program();
    int pulses = 0;
    int valid_cyc = 0;
    int halt_cyc = 0;
    fill_rom();
    rom_mem[0] = 8'h85;
    rom_mem[1] = 8'h23;
    rom_mem[2] = 8'h90;
    rom_mem[3] = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 2; i <= 12; i++) begin
      step();
      if (out_valid) begin
        pulses++;
        valid_cyc = i;
      end
      if (halted && halt_cyc == 0) halt_cyc = i;
    end
    checks++;
    if (out_data !== 4'h8 || acc !== 4'h8) begin
      errors++;
      $display("FAIL program_result: out=%h acc=%h expected 8 8", out_data, acc);
    end
    checks++;
    if (pulses !== 1 || valid_cyc !== 7) begin
      errors++;
      $display("FAIL program_valid: pulses=%0d cycle=%0d expected 1 7", pulses, valid_cyc);
    end
    checks++;
    if (halt_cyc !== 9 || busy !== 1'b0 || pc !== 12'h003) begin
      errors++;
      $display("FAIL program_halt: cycle=%0d busy=%b pc=%h expected 9 0 003", halt_cyc, busy, pc);
    end
  endtask

  task automatic test_alu_ops();
    fill_rom();
    rom_mem[0] = 8'h8A;
    rom_mem[1] = 8'h03;
    rom_mem[2] = 8'h33;
    rom_mem[3] = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (acc !== 4'hA) begin
      errors++;
      $display("FAIL alu_ldi: acc=%h expected a", acc);
    end
    step();
    checks++;
    if (alu_a !== 4'hA || alu_b !== 4'h3 || alu_sel !== 3'b000) begin
      errors++;
      $display("FAIL alu_operands: a=%h b=%h sel=%b expected a 3 000", alu_a, alu_b, alu_sel);
    end
    step();
    checks++;
    if (acc !== 4'h2 || alu_sel !== 3'b000) begin
      errors++;
      $display("FAIL alu_and: acc=%h sel=%b expected 2 000", acc, alu_sel);
    end
    step();
    checks++;
    if (alu_sel !== 3'b011 || pc_enable !== 1'b1) begin
      errors++;
      $display("FAIL alu_nop_sel: sel=%b en=%b expected 011 1", alu_sel, pc_enable);
    end
    step();
    checks++;
    if (acc !== 4'h2) begin
      errors++;
      $display("FAIL alu_nop_hold: acc=%h expected 2", acc);
    end
    step();
    step();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL alu_halt: halted=%b expected 1", halted);
    end
  endtask

  task automatic test_jz();
    fill_rom();
    rom_mem[0] = 8'h80;
    rom_mem[1] = 8'hB6;
    rom_mem[6] = 8'h81;
    rom_mem[7] = 8'hB2;
    rom_mem[8] = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    checks++;
    if (pc_load !== 1'b1 || pc_enable !== 1'b0 || pc_load_val !== 12'h006) begin
      errors++;
      $display("FAIL jz_taken: load=%b en=%b val=%h expected 1 0 006", pc_load, pc_enable, pc_load_val);
    end
    step();
    checks++;
    if (rom_addr !== 12'h006 || busy !== 1'b1) begin
      errors++;
      $display("FAIL jz_target: addr=%h busy=%b expected 006 1", rom_addr, busy);
    end
    step();
    step();
    step();
    checks++;
    if (acc !== 4'h1 || pc_enable !== 1'b1 || pc_load !== 1'b0) begin
      errors++;
      $display("FAIL jz_not_taken: acc=%h en=%b load=%b expected 1 1 0", acc, pc_enable, pc_load);
    end
    step();
    checks++;
    if (rom_addr !== 12'h008) begin
      errors++;
      $display("FAIL jz_fallthrough: addr=%h expected 008", rom_addr);
    end
    step();
    step();
    checks++;
    if (halted !== 1'b1 || acc !== 4'h1) begin
      errors++;
      $display("FAIL jz_halt: halted=%b acc=%h expected 1 1", halted, acc);
    end
  endtask

  task automatic test_jmp();
    logic found = 1'b0;
    fill_rom();
    rom_mem[12'h0F3] = 8'hAF;
    rom_mem[12'h0FF] = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    #1;
    checks++;
    if (pc_load !== 1'b0 || pc_enable !== 1'b0) begin
      errors++;
      $display("FAIL fetch_start_strobes: load=%b en=%b expected 0 0", pc_load, pc_enable);
    end
    step();
    start = 1'b0;
    checks++;
    if (pc !== 12'h001 || busy !== 1'b1 || pc_enable !== 1'b1) begin
      errors++;
      $display("FAIL fetch_start_ignored: pc=%h busy=%b en=%b expected 001 1 1", pc, busy, pc_enable);
    end
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (pc_load) found = 1'b1;
    end
    checks++;
    if (!found || pc !== 12'h0F3 || pc_load_val !== 12'h0FF) begin
      errors++;
      $display("FAIL jmp_page: found=%b pc=%h val=%h expected 1 0f3 0ff", found, pc, pc_load_val);
    end
    step();
    checks++;
    if (rom_addr !== 12'h0FF) begin
      errors++;
      $display("FAIL jmp_target: addr=%h expected 0ff", rom_addr);
    end
    step();
    step();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL jmp_halt: halted=%b expected 1", halted);
    end
  endtask

  task automatic test_restart();
    fill_rom();
    rom_mem[0] = 8'hC0;
    rom_mem[1] = 8'h8D;
    rom_mem[2] = 8'hF0;
    start = 1'b1;
    #1;
    checks++;
    if (pc_load !== 1'b1 || pc_load_val !== 12'h000 || acc !== 4'h1) begin
      errors++;
      $display("FAIL restart_load: load=%b val=%h acc=%h expected 1 000 1", pc_load, pc_load_val, acc);
    end
    step();
    start = 1'b0;
    checks++;
    if (rom_addr !== 12'h000 || busy !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL restart_fetch: addr=%h busy=%b halted=%b expected 000 1 0", rom_addr, busy, halted);
    end
    step();
    step();
    checks++;
    if (acc !== 4'h1 || pc !== 12'h001) begin
      errors++;
      $display("FAIL restart_retain: acc=%h pc=%h expected 1 001", acc, pc);
    end
    step();
    step();
    checks++;
    if (acc !== 4'hD) begin
      errors++;
      $display("FAIL restart_overwrite: acc=%h expected d", acc);
    end
    step();
    step();
    checks++;
    if (halted !== 1'b1 || out_data !== 4'h8) begin
      errors++;
      $display("FAIL restart_halt: halted=%b out=%h expected 1 8", halted, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_mid_exec_reset();
    test_program();
    test_alu_ops();
    test_jz();
    test_jmp();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
